sseg_bcd_fmt: RTL



---
 rtl/sseg_bcd_fmt.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sseg_bcd_fmt.sv
// Signed binary to packed BCD formatter with per-digit dp/sign controls for seven-segment decoders.
// Optional hex pass-through mode enabled by defining SSEG_FMT_HEX_EN.
module sseg_bcd_fmt #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [WIDTH-1:0]      value,
  input  logic [3:0]            dp_pos,
`ifdef SSEG_FMT_HEX_EN
  input  logic                  hex_mode,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   num_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     sign_out
);

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned BW      = 4 * DIGITS;
  localparam int unsigned MW      = WIDTH + 1;
  localparam int unsigned SW      = BW + MW;
  localparam int unsigned CW      = $clog2(WIDTH + 1);
  localparam int unsigned MAX_POS = pow10(DIGITS) - 1;
  localparam int unsigned MAX_NEG = pow10(DIGITS - 1) - 1;

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, LATCH} state_t;

  state_t           state;
  logic [WIDTH-1:0] val_q;
  logic [3:0]       dp_q;
  logic             neg_q;
  logic             ovf_q;
  logic [SW-1:0]    sr;
  logic [SW-1:0]    sr_adj;
  logic [CW-1:0]    cnt;
`ifdef SSEG_FMT_HEX_EN
  logic             hex_q;
`endif

  logic [MW-1:0]     val_ext;
  logic [MW-1:0]     mag;
  logic              neg_c;
  logic              ovf_c;
  logic [BW-1:0]     fmt_num;
  logic [DIGITS-1:0] fmt_dp;
  logic [DIGITS-1:0] fmt_sign;

  // One extra bit keeps the most negative input's magnitude representable.
  always_comb begin
    val_ext = {val_q[WIDTH-1], val_q};
    neg_c   = val_q[WIDTH-1];
    mag     = neg_c ? (MW'(0) - val_ext) : val_ext;
    ovf_c   = neg_c ? (32'(mag) > MAX_NEG) : (32'(mag) > MAX_POS);
  end

  always_comb begin
    sr_adj = sr;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (sr[MW+4*i +: 4] >= 4'd5)
        sr_adj[MW+4*i +: 4] = sr[MW+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    fmt_num  = sr[SW-1 -: BW];
    fmt_sign = '0;
    fmt_dp   = '0;
    for (int unsigned i = 0; i < DIGITS; i++)
      fmt_dp[i] = (dp_q == 4'(i + 1));
`ifdef SSEG_FMT_HEX_EN
    if (hex_q)
      fmt_num = BW'(val_q);
    else
`endif
    if (ovf_q) begin
      fmt_num  = '0;
      fmt_dp   = '0;
      fmt_sign = '1;
    end else if (neg_q) begin
      fmt_num[BW-1 -: 4]   = 4'd0;
      fmt_sign[DIGITS-1]   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      num_out  <= '0;
      dp_out   <= '0;
      sign_out <= '0;
      val_q    <= '0;
      dp_q     <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      sr       <= '0;
      cnt      <= '0;
`ifdef SSEG_FMT_HEX_EN
      hex_q    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            val_q <= value;
            dp_q  <= dp_pos;
`ifdef SSEG_FMT_HEX_EN
            hex_q <= hex_mode;
`endif
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          neg_q <= neg_c;
          ovf_q <= ovf_c;
          sr    <= {{BW{1'b0}}, mag};
          cnt   <= CW'(WIDTH);
          state <= SHIFT;
`ifdef SSEG_FMT_HEX_EN
          // Hex loads pass through here unconverted to keep done two edges after load.
          if (hex_q) state <= LATCH;
`endif
        end
        SHIFT: begin
          sr <= sr_adj << 1;
          if (cnt == '0) state <= LATCH;
          else           cnt   <= cnt - 1'b1;
        end
        LATCH: begin
          num_out  <= fmt_num;
          dp_out   <= fmt_dp;
          sign_out <= fmt_sign;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
